// File: rtl/wb_write_arbiter.sv
// Write-back arbiter: per-PE request FIFOs feeding both regfile write ports.
// Optional collision counter enabled with `define WB_STATS_EN.
module wb_write_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 37
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int PW = $clog2(DEPTH) + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;

  assign empty = (wptr == rptr);
  assign full  = (wptr ^ rptr) == {1'b1, {(PW-1){1'b0}}};
  assign dout  = mem[rptr[PW-2:0]];

  always_ff @(posedge clk) begin
    if (push)
      mem[wptr[PW-2:0]] <= din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push)
        wptr <= wptr + 1'b1;
      if (pop)
        rptr <= rptr + 1'b1;
    end
  end
endmodule

module wb_write_arbiter #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pe1_valid,
  output logic          pe1_ready,
  input  logic [AW-1:0] pe1_addr,
  input  logic [DW-1:0] pe1_data,
  input  logic          pe2_valid,
  output logic          pe2_ready,
  input  logic [AW-1:0] pe2_addr,
  input  logic [DW-1:0] pe2_data,
  output logic          we_pe1,
  output logic [AW-1:0] wa_pe1,
  output logic [DW-1:0] wd_pe1,
  output logic          we_pe2,
  output logic [AW-1:0] wa_pe2,
  output logic [DW-1:0] wd_pe2,
  output logic          idle,
  output logic [15:0]   conflict_cnt
);
  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wb_req_t;

  logic    armed;
  logic    full1, full2;
  logic    empty1, empty2;
  logic    push1, push2;
  logic    pop1, pop2;
  logic    collide;
  wb_req_t head1, head2;

  // Ready comes up one cycle after reset release
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      armed <= 1'b0;
    else
      armed <= 1'b1;
  end

  assign pe1_ready = armed & ~full1;
  assign pe2_ready = armed & ~full2;

  // x0 writes are accepted but never stored
  assign push1 = pe1_valid & pe1_ready & (|pe1_addr);
  assign push2 = pe2_valid & pe2_ready & (|pe2_addr);

  wb_write_fifo #(.DEPTH(DEPTH), .W(AW + DW)) u_fifo1 (
    .clk   (clk),
    .rst   (rst),
    .push  (push1),
    .din   ({pe1_addr, pe1_data}),
    .pop   (pop1),
    .dout  (head1),
    .full  (full1),
    .empty (empty1)
  );

  wb_write_fifo #(.DEPTH(DEPTH), .W(AW + DW)) u_fifo2 (
    .clk   (clk),
    .rst   (rst),
    .push  (push2),
    .din   ({pe2_addr, pe2_data}),
    .pop   (pop2),
    .dout  (head2),
    .full  (full2),
    .empty (empty2)
  );

  // On a collision PE2 is held so its value lands last
  assign collide = ~empty1 & ~empty2 & (head1.addr == head2.addr);
  assign pop1    = ~empty1;
  assign pop2    = ~empty2 & ~collide;
  assign idle    = empty1 & empty2;

  always_comb begin
    we_pe1 = 1'b0;
    wa_pe1 = '0;
    wd_pe1 = '0;
    we_pe2 = 1'b0;
    wa_pe2 = '0;
    wd_pe2 = '0;
    if (pop1) begin
      we_pe1 = 1'b1;
      wa_pe1 = head1.addr;
      wd_pe1 = head1.data;
    end
    if (pop2) begin
      we_pe2 = 1'b1;
      wa_pe2 = head2.addr;
      wd_pe2 = head2.data;
    end
  end

`ifdef WB_STATS_EN
  logic [15:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      cnt <= '0;
    else if (collide && cnt != 16'hFFFF)
      cnt <= cnt + 16'd1;
  end

  assign conflict_cnt = cnt;
`else
  assign conflict_cnt = 16'd0;
`endif
endmodule
